// File: rtl/dm_pkg.sv
// Shared definitions for the dm_bytelane data memory: access-type codes,
// clear-engine state codes and the alignment helper.
package dm_pkg;

  // mem_op access types; codes 3'b101..3'b111 are unused (no write, load 0)
  localparam logic [2:0] MOP_W  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_HU = 3'b010;
  localparam logic [2:0] MOP_B  = 3'b011;
  localparam logic [2:0] MOP_BU = 3'b100;

  // clear engine states
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;

  // True when the access type needs stricter alignment than addr provides.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic m;
    m = 1'b0;
    case (op)
      MOP_W:         m = (lo != 2'b00);
      MOP_H, MOP_HU: m = lo[0];
      default:       m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension from a full memory word.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  mem_op,
  output logic [31:0] rd
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  // pick the addressed half and byte out of the word
  always_comb begin
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
  end

  // extend the selected lane according to the access type
  always_comb begin
    rd = '0;
    case (mem_op)
      MOP_W:   rd = word;
      MOP_H:   rd = {{16{half_v[15]}}, half_v};
      MOP_HU:  rd = {16'h0000, half_v};
      MOP_B:   rd = {{24{byte_v[7]}}, byte_v};
      MOP_BU:  rd = {24'h000000, byte_v};
      default: rd = '0;
    endcase
  end

endmodule

// File: rtl/dm_bytelane.sv
// Byte-lane data memory for the MIPS datapath. Word/half/byte stores,
// signed/unsigned loads, alignment and range checking, first-fault capture
// and a one-word-per-cycle clear engine run after reset or on clr_req.
// Optional store/fault trace output when DM_BYTELANE_TRACE_EN is defined.
//
// Handshake: there is no per-access valid; the access presented on
// we/mem_op/addr/wd/pc is evaluated every cycle. ready=1 means the array is
// usable; while ready=0 loads return 0, stores are dropped and no fault is
// recorded. A store commits at the rising edge when ready=1, we=1,
// addr_err=0 and clr_req=0.
module dm_bytelane
  import dm_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [31:0] pc,
  input  logic        clr_req,
  output logic [31:0] rd,
  output logic        ready,
  output logic        addr_err,
  output logic        err_valid,
  output logic [31:0] err_pc,
  output logic        dbg_state
);

  logic [31:0]      mem [DEPTH];
  logic             state;
  logic [IDX_W-1:0] clr_idx;
  logic [IDX_W-1:0] idx;
  logic             out_of_range;
  logic             mis;
  logic             op_known;
  logic             store_ok;
  logic [31:0]      cur_word;
  logic [31:0]      wr_word;
  logic [31:0]      ld_rd;

  // address decode and access qualification
  always_comb begin
    idx          = addr[IDX_W+1:2];
    out_of_range = |addr[31:IDX_W+2];
    mis          = misaligned(mem_op, addr[1:0]);
    ready        = (state == ST_READY);
    addr_err     = ready & (out_of_range | mis);
    op_known     = (mem_op <= MOP_BU);
    store_ok     = ready & we & ~addr_err & ~clr_req & op_known;
    cur_word     = mem[idx];
    dbg_state    = state;
  end

  // merge store data into the addressed lanes, keeping the others
  always_comb begin
    wr_word = cur_word;
    case (mem_op)
      MOP_W: wr_word = wd;
      MOP_H, MOP_HU: begin
        if (addr[1]) wr_word[31:16] = wd[15:0];
        else         wr_word[15:0]  = wd[15:0];
      end
      MOP_B, MOP_BU: begin
        case (addr[1:0])
          2'd0:    wr_word[7:0]   = wd[7:0];
          2'd1:    wr_word[15:8]  = wd[7:0];
          2'd2:    wr_word[23:16] = wd[7:0];
          default: wr_word[31:24] = wd[7:0];
        endcase
      end
      default: wr_word = cur_word;
    endcase
  end

  dm_load_ext u_load_ext (
    .word   (cur_word),
    .lane   (addr[1:0]),
    .mem_op (mem_op),
    .rd     (ld_rd)
  );

  // load data is forced to zero while clearing or on a faulting access
  always_comb begin
    rd = (ready & ~addr_err) ? ld_rd : '0;
  end

  // array write port: clear sweep has the port while clearing, stores otherwise
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) mem[clr_idx] <= '0;
    else if (store_ok)     mem[idx]     <= wr_word;
  end

  // clear engine: sweep every word once, then serve accesses until clr_req
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state   <= ST_READY;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + IDX_W'(1);
          end
        end
        default: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
          end
        end
      endcase
    end
  end

  // sticky first-fault capture; a clear request wipes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_valid <= 1'b0;
      err_pc    <= '0;
    end else if (ready && clr_req) begin
      err_valid <= 1'b0;
      err_pc    <= '0;
    end else if (addr_err && !err_valid) begin
      err_valid <= 1'b1;
      err_pc    <= pc;
    end
  end

`ifdef DM_BYTELANE_TRACE_EN
  // simulation trace of committed stores and captured faults
  always @(posedge clk) begin
    if (reset && store_ok)
      $display("@%08h: *%08h <= %08h", pc, addr, wd);
    if (reset && addr_err && !err_valid && !clr_req)
      $display("@%08h: DM fault %08h", pc, addr);
  end
`else
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
// Directed bench for dm_bytelane (DEPTH=16). The driver pushes the expected
// {ready, addr_err, err_valid, err_pc, rd} tuple for each access; a monitor
// on the falling edge pops and compares.
module tb_dm_bytelane;
  import dm_pkg::*;

  localparam int DEPTH = 16;
  localparam int EW    = 67;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        we = 1'b0;
  logic [2:0]  mem_op = MOP_W;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] pc = '0;
  logic        clr_req = 1'b0;
  logic [31:0] rd;
  logic        ready;
  logic        addr_err;
  logic        err_valid;
  logic [31:0] err_pc;
  logic        dbg_state;

  dm_bytelane #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .mem_op    (mem_op),
    .addr      (addr),
    .wd        (wd),
    .pc        (pc),
    .clr_req   (clr_req),
    .rd        (rd),
    .ready     (ready),
    .addr_err  (addr_err),
    .err_valid (err_valid),
    .err_pc    (err_pc),
    .dbg_state (dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  logic          chk = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  // monitor: compare the presented outputs against the oldest expectation
  always @(negedge clk) begin
    if (chk) begin
      logic [EW-1:0] got;
      logic [EW-1:0] want;
      string         nm;
      got = {ready, addr_err, err_valid, err_pc, rd};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL underflow: got %h, required a queued expectation", got);
      end else begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        if (got !== want) begin
          n_errors++;
          $display("FAIL %s: got rdy=%0b err=%0b ev=%0b epc=%h rd=%h, required rdy=%0b err=%0b ev=%0b epc=%h rd=%h",
                   nm, got[66], got[65], got[64], got[63:32], got[31:0],
                   want[66], want[65], want[64], want[63:32], want[31:0]);
        end
      end
    end
  end

  // driver: present one access for a cycle and queue its expected response
  task automatic acc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                     input logic w, input logic c, input logic [31:0] p,
                     input logic erdy, input logic eerr, input logic [31:0] erd,
                     input logic ev, input logic [31:0] epc, input string nm);
    @(posedge clk);
    #1;
    mem_op = op; addr = a; wd = d; we = w; clr_req = c; pc = p;
    exp_q.push_back({erdy, eerr, ev, epc, erd});
    name_q.push_back(nm);
    chk = 1'b1;
    @(negedge clk);
    #1;
    chk = 1'b0;
  endtask

  // ready-state load without error history
  task automatic ld(input logic [2:0] op, input logic [31:0] a, input logic [31:0] erd,
                    input logic ev, input logic [31:0] epc, input string nm);
    acc(op, a, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, erd, ev, epc, nm);
  endtask

  // ready-state aligned store; erd is the old data visible during the write
  task automatic st(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] erd, input string nm);
    acc(op, a, d, 1'b1, 1'b0, 32'h1000, 1'b1, 1'b0, erd, 1'b0, 32'h0, nm);
  endtask

  initial begin
    // reset held low: clear state, no error history
    acc(MOP_W, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "rst_low0");
    acc(MOP_W, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "rst_low1");
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 1; k <= DEPTH; k++)
      acc(MOP_W, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, (k == DEPTH), 1'b0, 32'h0, 1'b0, 32'h0,
          $sformatf("sweep_%0d", k));
    for (int i = 0; i < DEPTH; i++)
      ld(MOP_W, 32'(i * 4), 32'h0, 1'b0, 32'h0, $sformatf("zero_w%0d", i));

    // word store, then lane loads
    st(MOP_W, 32'h10, 32'h12345678, 32'h0, "st_w10");
    ld(MOP_W,  32'h10, 32'h12345678, 1'b0, 32'h0, "ld_w10");
    ld(MOP_B,  32'h11, 32'h00000056, 1'b0, 32'h0, "ld_b11");
    ld(MOP_BU, 32'h13, 32'h00000012, 1'b0, 32'h0, "ld_bu13");
    ld(MOP_H,  32'h12, 32'h00001234, 1'b0, 32'h0, "ld_h12");
    ld(MOP_HU, 32'h10, 32'h00005678, 1'b0, 32'h0, "ld_hu10");
    ld(MOP_B,  32'h10, 32'h00000078, 1'b0, 32'h0, "ld_b10");

    // sign vs zero extension
    st(MOP_W, 32'h20, 32'h0000FF80, 32'h0, "st_w20");
    ld(MOP_B,  32'h20, 32'hFFFFFF80, 1'b0, 32'h0, "ld_b20");
    ld(MOP_BU, 32'h20, 32'h00000080, 1'b0, 32'h0, "ld_bu20");
    ld(MOP_H,  32'h20, 32'hFFFFFF80, 1'b0, 32'h0, "ld_h20");
    ld(MOP_HU, 32'h20, 32'h0000FF80, 1'b0, 32'h0, "ld_hu20");

    // partial stores merge into the existing word
    st(MOP_W, 32'h20, 32'h11223344, 32'h0000FF80, "st_w20b");
    st(MOP_B, 32'h21, 32'h123456AB, 32'h00000033, "st_b21");
    ld(MOP_W, 32'h20, 32'h1122AB44, 1'b0, 32'h0, "ld_merge_b");
    st(MOP_H, 32'h22, 32'h7777BEEF, 32'h00001122, "st_h22");
    ld(MOP_W, 32'h20, 32'hBEEFAB44, 1'b0, 32'h0, "ld_merge_h");
    st(3'b101, 32'h20, 32'h0, 32'h0, "st_op101");
    ld(MOP_W, 32'h20, 32'hBEEFAB44, 1'b0, 32'h0, "ld_after101");
    ld(MOP_H, 32'h22, 32'hFFFFBEEF, 1'b0, 32'h0, "ld_h22");
    ld(MOP_B, 32'h23, 32'hFFFFFFBE, 1'b0, 32'h0, "ld_b23");

    // last word in range
    st(MOP_W, 32'h3C, 32'hCAFEF00D, 32'h0, "st_w3c");
    ld(MOP_W, 32'h3C, 32'hCAFEF00D, 1'b0, 32'h0, "ld_w3c");

    // faults: first one is captured, later ones leave err_pc alone
    acc(MOP_W, 32'h06, 32'hDEADBEEF, 1'b1, 1'b0, 32'h3008, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, "flt_mis");
    ld(MOP_W, 32'h04, 32'h0, 1'b1, 32'h3008, "flt_unchanged");
    acc(MOP_W, 32'h40, 32'h1, 1'b1, 1'b0, 32'h300C, 1'b1, 1'b1, 32'h0, 1'b1, 32'h3008, "flt_oor");
    ld(MOP_W, 32'h3C, 32'hCAFEF00D, 1'b1, 32'h3008, "flt_sticky");
    acc(MOP_H, 32'h21, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h3008, "flt_h_odd");
    ld(MOP_B,  32'h21, 32'hFFFFFFAB, 1'b1, 32'h3008, "ld_b21");
    ld(MOP_HU, 32'h22, 32'h0000BEEF, 1'b1, 32'h3008, "ld_hu22");

    // clear request drops the concurrent store and wipes error state
    acc(MOP_W, 32'h0, 32'h99, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3008, "st_w0");
    acc(MOP_W, 32'h0, 32'h55, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h99, 1'b1, 32'h3008, "clr_st");
    for (int j = 1; j <= DEPTH + 1; j++) begin
      if (j == 3)
        acc(MOP_W, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "clr_ignored");
      else if (j == 5)
        acc(MOP_W, 32'h4, 32'hDEAD, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "st_in_clear");
      else
        acc(MOP_W, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, (j == DEPTH + 1), 1'b0, 32'h0, 1'b0, 32'h0,
            $sformatf("clr_%0d", j));
    end
    ld(MOP_W, 32'h04, 32'h0, 1'b0, 32'h0, "clr_w4");
    ld(MOP_W, 32'h3C, 32'h0, 1'b0, 32'h0, "clr_w3c");

    // reset during a sweep restarts it from index 0
    st(MOP_W, 32'h08, 32'h77, 32'h0, "st_w8");
    ld(MOP_W, 32'h08, 32'h77, 1'b0, 32'h0, "ld_w8");
    acc(MOP_W, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "clr2");
    for (int j = 1; j <= 5; j++)
      acc(MOP_W, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
          $sformatf("clr2_%0d", j));
    @(posedge clk);
    #1 reset = 1'b0;
    acc(MOP_W, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "rst_mid");
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 1; k <= DEPTH; k++)
      acc(MOP_W, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, (k == DEPTH), 1'b0, 32'h0, 1'b0, 32'h0,
          $sformatf("resweep_%0d", k));
    ld(MOP_W, 32'h08, 32'h0, 1'b0, 32'h0, "resweep_w8");

    // report
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_bytelane.md
Name: dm_bytelane

Overview:
- Parametrised data memory for the single-cycle/multi-cycle MIPS datapath.
- Supports word/half/byte stores, and signed/unsigned half and byte loads, with alignment and range checking.
- After reset or a clear request, a sequential clear engine zeroes the array one word per cycle, so the array is never reset in a single cycle.
- Sits between the ALU address output and the writeback mux.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of 2, minimum 4.
- IDX_W, $clog2(DEPTH), word index width; derived, do not override.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces clear engine to its initial state immediately.
- we  in  1  store enable for the current access.
- mem_op  in  3  access type; encoding in the package.
- addr  in  32  byte address.
- wd  in  32  store data; low 16/8 bits used for H/B stores.
- pc  in  32  PC of the current instruction; used for error capture and trace.
- clr_req  in  1  synchronous request to re-zero the array.
- rd  out  32  load data, extended per mem_op; combinational.
- ready  out  1  1 = array usable; 0 = clear in progress.
- addr_err  out  1  combinational; current access is misaligned or out of range.
- err_valid  out  1  sticky; set on the first faulting access.
- err_pc  out  32  pc of the first faulting access.

Behaviour:
- State machine:
  - States are CLEAR and READY.
  - On reset low: state=CLEAR, clr_idx=0, err_valid=0, err_pc=0. ready=0 while in CLEAR.
  - In CLEAR, each rising edge writes mem[clr_idx]=0 and increments clr_idx.
  - When clr_idx==DEPTH-1 is written, go to READY and wrap clr_idx to 0.
  - ready rises exactly DEPTH edges after reset deasserts.
  - In READY, clr_req=1 moves to CLEAR on the next edge and also clears err_valid/err_pc. The store in that cycle is dropped (clr_req has priority).
  - clr_req during CLEAR is ignored; the sweep is not restarted.
  - Reset asserted mid-clear restarts the sweep at index 0.
- While ready=0: rd=0, addr_err=0, stores ignored, no error capture.
- Index is addr[IDX_W+1:2].
- Out of range: addr[31:IDX_W+2] != 0.
- Misaligned:
  - W with addr[1:0]!=0.
  - H/HU with addr[0]!=0.
  - B/BU are never misaligned.
- addr_err = ready & (out of range | misaligned). Asserted for loads and stores alike.
- Stores (we=1, ready=1, addr_err=0, clr_req=0), written at the rising edge:
  - W writes the full word.
  - H/HU writes wd[15:0] into bits [31:16] if addr[1], else [15:0].
  - B/BU writes wd[7:0] into byte lane addr[1:0]; lane 0 = bits [7:0].
  - Unwritten lanes keep their value.
  - mem_op 101–111 with we=1: no write, not an error.
- Loads (combinational from the current array contents):
  - W returns the word.
  - H/B sign-extend the selected lane.
  - HU/BU zero-extend the selected lane.
  - Codes 101–111 return 0.
  - addr_err=1 → rd=0.
- Read-during-write to the same address returns the old data; the new data is visible from the next cycle.
- Error capture: on an edge where addr_err=1 and err_valid=0, set err_valid=1 and err_pc=pc. Later faults do not overwrite it.

Optional Feature:
- Macro DM_BYTELANE_TRACE_EN.
- When defined: every committed store prints "@<pc>: *<addr> <= <wd>" (hex, 8 digits) at the write edge. Every captured fault prints "@<pc>: DM fault <addr>".
- When undefined: no simulation output, and no logic differences.

Decomposition:
- Package dm_pkg holds:
  - mem_op encodings: MOP_W=3'b000, MOP_H=3'b001, MOP_HU=3'b010, MOP_B=3'b011, MOP_BU=3'b100.
  - State encodings: ST_CLEAR, ST_READY.
- One sub-module, dm_load_ext: combinational lane select plus sign/zero extension from (word, addr[1:0], mem_op) to rd.
- Store lane merge stays in the top level.

Test Plan:
- Reset pulse low, then high, with DEPTH=16 → ready=0 for 16 edges, then 1; every word reads 0.
- Store W 0x12345678 @0x10, then load B@0x11 → 0x00000056. BU@0x13 → 0x00000012. H@0x12 → 0x00001234.
- Store W 0x0000FF80 @0x20. Load B@0x20 → 0xFFFFFF80. BU@0x20 → 0x00000080. H@0x20 → 0xFFFFFF80. HU@0x20 → 0x0000FF80.
- Store B 0xAB@0x21 over 0x11223344 → word reads 0x1122AB44. Store H 0xBEEF@0x22 → 0xBEEFAB44.
- Store W @0x06 (pc=0x3008), then store W @(DEPTH*4) (pc=0x300C):
  - First access: addr_err=1, memory unchanged, err_valid=1, err_pc=0x3008.
  - Second access: err_pc stays 0x3008.
- clr_req together with store W 0x55@0x0 → store dropped; ready low for DEPTH cycles; word 0 reads 0; err_valid=0. Reset low mid-clear → sweep restarts, ready rises DEPTH edges after release.
